muu_resp_arbiter: RTL and testbench



---
 rtl/muu_resp_arbiter.sv | 133 +++++++++++++
 tb/tb_muu_resp_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muu_resp_arbiter.sv
// Packet-granular round-robin merge of two response streams with max-length enforcement.
// Optional per-source packet and truncation counters when MUU_RESP_ARB_STATS_EN is defined.
module muu_resp_arbiter #(
    parameter int META_WIDTH          = 96,
    parameter int MAX_WORDS_IN_PACKET = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [META_WIDTH+511:0] in0_data,
    input  logic [7:0]              in0_user,
    input  logic                    in0_valid,
    input  logic                    in0_last,
    output logic                    in0_ready,
    input  logic [META_WIDTH+511:0] in1_data,
    input  logic [7:0]              in1_user,
    input  logic                    in1_valid,
    input  logic                    in1_last,
    output logic                    in1_ready,
    output logic [META_WIDTH+511:0] out_data,
    output logic [7:0]              out_user,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    trunc_err
`ifdef MUU_RESP_ARB_STATS_EN
    ,
    output logic [31:0]             pkt_cnt0,
    output logic [31:0]             pkt_cnt1,
    output logic [15:0]             trunc_cnt
`endif
);

    localparam int         DW       = META_WIDTH + 512;
    localparam logic [9:0] LAST_IDX = 10'(MAX_WORDS_IN_PACKET - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PASS
    } state_t;

    state_t      state;
    logic        grant;
    logic        prio;
    logic [9:0]  beat_cnt;

    logic          out_free;
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic [7:0]    sel_user;
    logic          accept;
    logic          at_limit;
    logic          eff_last;

    always_comb begin
        out_free  = !out_valid || out_ready;
        sel_valid = grant ? in1_valid : in0_valid;
        sel_last  = grant ? in1_last  : in0_last;
        sel_data  = grant ? in1_data  : in0_data;
        sel_user  = grant ? in1_user  : in0_user;
        in0_ready = (state == ST_PASS) && !grant && out_free;
        in1_ready = (state == ST_PASS) &&  grant && out_free;
        accept    = (state == ST_PASS) && sel_valid && out_free;
        at_limit  = (beat_cnt == LAST_IDX);
        eff_last  = sel_last || at_limit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= 1'b0;
            prio      <= 1'b0;
            beat_cnt  <= '0;
            out_data  <= '0;
            out_user  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in0_valid || in1_valid) begin
                        grant    <= (in0_valid && in1_valid) ? prio : in1_valid;
                        beat_cnt <= '0;
                        state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (accept) begin
                        trunc_err <= at_limit && !sel_last;
                        // Clearing on packet end keeps beat_cnt within MAX_WORDS_IN_PACKET-1.
                        if (eff_last) begin
                            beat_cnt <= '0;
                            prio     <= ~grant;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 10'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_user  <= sel_user;
                out_last  <= eff_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUU_RESP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (accept && eff_last) begin
                if (grant) pkt_cnt1 <= pkt_cnt1 + 32'd1;
                else       pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (accept && at_limit && !sel_last && trunc_cnt != '1)
                trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_muu_resp_arbiter.sv
// Randomized and directed bench for muu_resp_arbiter against a packet-level reference model.
module tb_muu_resp_arbiter;
    localparam int MW   = 96;
    localparam int W    = MW + 512;
    localparam int MAXW = 4;

    typedef struct {
        logic [W-1:0] data;
        logic [7:0]   user;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic [7:0]   in0_user = '0, in1_user = '0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic         in0_last = 1'b0, in1_last = 1'b0;
    logic         in0_ready, in1_ready;
    logic [W-1:0] out_data;
    logic [7:0]   out_user;
    logic         out_valid, out_last;
    logic         out_ready = 1'b1;
    logic         trunc_err;
`ifdef MUU_RESP_ARB_STATS_EN
    logic [31:0]  pkt_cnt0, pkt_cnt1;
    logic [15:0]  trunc_cnt;
`endif

    always #5 clk = ~clk;

    muu_resp_arbiter #(
        .META_WIDTH(MW),
        .MAX_WORDS_IN_PACKET(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_user(in0_user), .in0_valid(in0_valid),
        .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_user(in1_user), .in1_valid(in1_valid),
        .in1_last(in1_last), .in1_ready(in1_ready),
        .out_data(out_data), .out_user(out_user), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .trunc_err(trunc_err)
`ifdef MUU_RESP_ARB_STATS_EN
        , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
`endif
    );

    // Source queues, copies of everything sent, and the beats seen leaving the output.
    beat_t q0[$], q1[$], sent0[$], sent1[$], obs[$];
    bit    pres0, pres1;
    int    vprob = 100;
    int    tests = 0, fails = 0, cyc = 0;
    logic  bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reference model: owner -1 means no packet in progress.
    int           m_owner, m_fav, m_nb, m_pc0, m_pc1, m_tc;
    logic         m_ov, m_ol, m_tr;
    logic [W-1:0] m_od;
    logic [7:0]   m_ou;

    int first_iv, first_ov, trunc_seen, trunc_idx, in1_rdy_seen;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_data(input int s);
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        d[0] = s[0];
        return d;
    endfunction

    task automatic push_pkt(input int s, input int len, input logic [7:0] user);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rand_data(s);
            b.user = user;
            b.last = (i == len - 1);
            if (s == 0) begin q0.push_back(b); sent0.push_back(b); end
            else        begin q1.push_back(b); sent1.push_back(b); end
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_fav = 0; m_nb = 0;
        m_pc0 = 0; m_pc1 = 0; m_tc = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_tr = 1'b0;
        m_od = '0; m_ou = '0;
    endtask

    task automatic cycle(input logic ordy);
        beat_t b;
        logic  ack;
        int    s;
        @(negedge clk);
        cyc++;
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("trunc_err", W'(trunc_err), W'(m_tr));
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_user", W'(out_user), W'(m_ou));
            chk("out_last", W'(out_last), W'(m_ol));
        end
`ifdef MUU_RESP_ARB_STATS_EN
        chk("pkt_cnt0", W'(pkt_cnt0), W'(m_pc0));
        chk("pkt_cnt1", W'(pkt_cnt1), W'(m_pc1));
        chk("trunc_cnt", W'(trunc_cnt), W'(m_tc));
`endif
        if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
        if (trunc_err === 1'b1) begin trunc_seen++; trunc_idx = obs.size(); end

        if (!pres0 && q0.size() > 0 && $urandom_range(0, 99) < vprob) pres0 = 1;
        if (!pres1 && q1.size() > 0 && $urandom_range(0, 99) < vprob) pres1 = 1;
        if (pres0 && first_iv < 0) first_iv = cyc;
        in0_valid = pres0;
        in0_data  = pres0 ? q0[0].data : rand_data(0);
        in0_user  = pres0 ? q0[0].user : 8'($urandom);
        in0_last  = pres0 ? q0[0].last : 1'($urandom_range(0, 1));
        in1_valid = pres1;
        in1_data  = pres1 ? q1[0].data : rand_data(1);
        in1_user  = pres1 ? q1[0].user : 8'($urandom);
        in1_last  = pres1 ? q1[0].last : 1'($urandom_range(0, 1));
        out_ready = ordy;
        #1;
        chk("in0_ready", W'(in0_ready), W'(m_owner == 0 && (!m_ov || ordy)));
        chk("in1_ready", W'(in1_ready), W'(m_owner == 1 && (!m_ov || ordy)));
        if (in1_ready === 1'b1) in1_rdy_seen++;
        if (out_valid === 1'b1 && ordy) begin
            b.data = out_data; b.user = out_user; b.last = out_last;
            obs.push_back(b);
        end

        m_tr = 1'b0;
        if (m_owner < 0) begin
            if (m_ov && ordy) m_ov = 1'b0;
            if (pres0 || pres1) begin
                m_owner = (pres0 && pres1) ? m_fav : (pres0 ? 0 : 1);
                m_nb = 0;
            end
        end else begin
            s   = m_owner;
            ack = (s == 0 ? pres0 : pres1) && (!m_ov || ordy);
            if (ack) begin
                if (s == 0) begin b = q0.pop_front(); pres0 = 0; end
                else        begin b = q1.pop_front(); pres1 = 0; end
                m_nb++;
                m_ov = 1'b1; m_od = b.data; m_ou = b.user;
                m_ol = b.last || (m_nb == MAXW);
                m_tr = (m_nb == MAXW) && !b.last;
                if (m_tr && m_tc < 65535) m_tc++;
                if (m_ol) begin
                    if (s == 0) m_pc0++; else m_pc1++;
                    m_owner = -1;
                    m_fav   = 1 - s;
                end
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic drain(input int budget, input int mode);
        int   n = 0;
        logic r;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0 || m_ov) && n < budget) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = bp_pat[cyc % 4];
            endcase
            cycle(r);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL drain_timeout: got %0d cycles, limit %0d", n, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pres0 = 0; pres1 = 0;
        q0.delete(); q1.delete(); sent0.delete(); sent1.delete(); obs.delete();
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_user", W'(out_user), '0);
        chk("rst_in0_ready", W'(in0_ready), '0);
        chk("rst_in1_ready", W'(in1_ready), '0);
        chk("rst_trunc_err", W'(trunc_err), '0);
`ifdef MUU_RESP_ARB_STATS_EN
        chk("rst_pkt_cnt0", W'(pkt_cnt0), '0);
        chk("rst_pkt_cnt1", W'(pkt_cnt1), '0);
        chk("rst_trunc_cnt", W'(trunc_cnt), '0);
`endif
        model_reset();
        first_iv = -1; first_ov = -1; trunc_seen = 0; trunc_idx = -1; in1_rdy_seen = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, i0, i1;
        model_reset();

        // Single source, 3-beat packet.
        do_reset();
        vprob = 100;
        push_pkt(0, 3, 8'hA1);
        drain(50, 0);
        chk("t1_latency", W'(first_ov - first_iv), W'(2));
        chk("t1_beats", W'(obs.size()), W'(3));
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            chk("t1_last", W'(obs[i].last), W'(i == 2));
            chk("t1_data", obs[i].data, sent0[i].data);
        end
        chk("t1_in1_ready", W'(in1_rdy_seen), '0);

        // Contention: 4 two-beat packets per source, both valid at release.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 2, 8'(8'h10 + p));
            push_pkt(1, 2, 8'(8'h20 + p));
        end
        drain(200, 0);
        chk("t2_beats", W'(obs.size()), W'(16));
        for (int i = 0; i < obs.size() && i < 16; i++) begin
            chk("t2_src", W'(obs[i].data[0]), W'((i / 2) % 2));
            chk("t2_last", W'(obs[i].last), W'(i % 2 == 1));
        end
`ifdef MUU_RESP_ARB_STATS_EN
        chk("t2_pkt_cnt0", W'(pkt_cnt0), W'(4));
        chk("t2_pkt_cnt1", W'(pkt_cnt1), W'(4));
`endif

        // Back-pressure on a 5-beat in1 packet (cut at MAXW beats).
        do_reset();
        push_pkt(1, 5, 8'h5B);
        drain(100, 2);
        chk("t3_beats", W'(obs.size()), W'(5));
        for (int i = 0; i < obs.size() && i < 5; i++) begin
            chk("t3_data", obs[i].data, sent1[i].data);
            chk("t3_user", W'(obs[i].user), W'(8'h5B));
            chk("t3_last", W'(obs[i].last), W'(i == 3 || i == 4));
        end

        // Truncation of a 6-beat packet, then an exactly-MAXW packet.
        do_reset();
        push_pkt(0, 6, 8'h66);
        drain(100, 0);
        chk("t4_beats", W'(obs.size()), W'(6));
        for (int i = 0; i < obs.size() && i < 6; i++)
            chk("t4_last", W'(obs[i].last), W'(i == 3 || i == 5));
        chk("t4_trunc_pulses", W'(trunc_seen), W'(1));
        chk("t4_trunc_beat", W'(trunc_idx), W'(3));
`ifdef MUU_RESP_ARB_STATS_EN
        chk("t4_trunc_cnt", W'(trunc_cnt), W'(1));
`endif
        trunc_seen = 0;
        push_pkt(1, 4, 8'h44);
        drain(100, 0);
        chk("t4_exact_no_trunc", W'(trunc_seen), '0);
        chk("t4_exact_beats", W'(obs.size()), W'(10));
        for (int i = 6; i < obs.size() && i < 10; i++)
            chk("t4_exact_last", W'(obs[i].last), W'(i == 9));

        // Reset mid-packet, then a fresh in1 packet.
        do_reset();
        push_pkt(0, 4, 8'h77);
        n = 0;
        while (m_nb < 2 && n < 20) begin cycle(1'b1); n++; end
        chk("t5_reached_beat2", W'(m_nb), W'(2));
        do_reset();
        push_pkt(1, 3, 8'h88);
        drain(50, 0);
        chk("t5_beats", W'(obs.size()), W'(3));
        for (int i = 0; i < obs.size() && i < 3; i++) begin
            chk("t5_data", obs[i].data, sent1[i].data);
            chk("t5_last", W'(obs[i].last), W'(i == 2));
        end

        // Randomized traffic with random back-pressure.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            vprob = int'($urandom_range(30, 100));
            for (int s = 0; s < 2; s++)
                for (int p = 0; p < int'($urandom_range(1, 5)); p++)
                    push_pkt(s, int'($urandom_range(1, 7)), 8'($urandom));
            drain(3000, 1);
        end
        i0 = 0; i1 = 0;
        foreach (obs[i]) begin
            if (obs[i].data[0]) begin
                if (i1 < sent1.size()) begin
                    chk("rand_data1", obs[i].data, sent1[i1].data);
                    chk("rand_user1", W'(obs[i].user), W'(sent1[i1].user));
                end
                i1++;
            end else begin
                if (i0 < sent0.size()) begin
                    chk("rand_data0", obs[i].data, sent0[i0].data);
                    chk("rand_user0", W'(obs[i].user), W'(sent0[i0].user));
                end
                i0++;
            end
        end
        chk("rand_count0", W'(i0), W'(sent0.size()));
        chk("rand_count1", W'(i1), W'(sent1.size()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
